// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit and its fetch queue.
package ifu_pkg;

    localparam int WORDSIZE    = 4;
    localparam int IFU_ADDR_W  = 32;
    localparam int IFU_INSTR_W = 32;

    localparam logic [IFU_INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0]  pc;
        logic [IFU_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} fetch entries; clear has priority over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction fetch stage: PC, in-order fetch issue, prefetch queue and redirect flush.
// Optional perf counters perf_fetched/perf_flushed are built when IFU_PERF_CNT_EN is defined.
module instr_prefetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   rsp_pc;
    logic [ADDR_W-1:0]   redir_target;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       discard;
    logic [CW-1:0]       count;
    logic [CW+1:0]       occupancy;
    logic                credit_ok;
    logic                fire;
    logic                rsp_drop;
    logic                live_rsp;
    logic                q_full;
    logic                q_empty;

    assign redir_target = {redir_pc[ADDR_W-1:2], 2'b00};
    // inflight counts live outstanding words, discard the stale ones; both hold a queue credit.
    assign occupancy    = (CW+2)'(inflight) + (CW+2)'(discard) + (CW+2)'(count);
    assign credit_ok    = occupancy < (CW+2)'(DEPTH);
    assign fire         = imem_req_valid && imem_req_ready;
    assign rsp_drop     = imem_rsp_valid && (redir_valid || discard != '0);
    assign live_rsp     = imem_rsp_valid && !rsp_drop;
    assign imem_req_addr = pc;
    assign dec_valid    = !q_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run)  state_d = ST_FETCH;
            ST_FETCH: if (!run) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == ST_FETCH) && !redir_valid && credit_ok;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else if (redir_valid) begin
            pc       <= redir_target;
            rsp_pc   <= redir_target;
            inflight <= '0;
            discard  <= inflight + discard - CW'(imem_rsp_valid);
        end else begin
            if (fire) pc <= pc + ADDR_W'(WORDSIZE);
            // Responses are in order and sequential, so the next live word belongs to rsp_pc.
            if (live_rsp) rsp_pc <= rsp_pc + ADDR_W'(WORDSIZE);
            inflight <= inflight + CW'(fire) - CW'(live_rsp);
            discard  <= discard - CW'(rsp_drop);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + INSTR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (live_rsp),
        .pop     (dec_ready),
        .clear   (redir_valid),
        .wr_data ({rsp_pc, imem_rsp_data}),
        .rd_data ({dec_pc, dec_instr}),
        .full    (q_full),
        .empty   (q_empty),
        .count   (count)
    );

`ifdef IFU_PERF_CNT_EN
    logic [32:0] flushed_sum;
    logic        fetched_inc;

    assign fetched_inc = dec_valid && dec_ready && !redir_valid;
    assign flushed_sum = {1'b0, perf_flushed} + 33'(redir_valid ? count : '0) + 33'(rsp_drop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (fetched_inc && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: memory responder, stream-level reference model and scenario tasks.
module tb_instr_prefetch_unit;
    import ifu_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    logic        clock;
    logic        reset;
    logic        run;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int           n_checks = 0;
    int           n_fail   = 0;
    mem_req_t     pipe[$];
    fetch_entry_t exp_q[$];
    int           cyc = 0;
    int           epoch = 0;
    int           outstanding = 0;
    int           accepted_cnt = 0;
    int           pops = 0;
    int           fetched_m = 0;
    int           flushed_m = 0;
    logic [31:0]  exp_req = RESET_PC;
    logic [31:0]  last_addr = '0;
    bit           fetch_on = 0;
    int           ready_mode = 0;
    int           lat_min = 1;
    int           lat_max = 1;
    bit           rsp_gaps = 0;

    instr_prefetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return h ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder and reference model: the decode stream is the in-order list of
    // words fetched since the last redirect/reset; older responses are stale.
    initial begin : mem_model
        mem_req_t     head;
        fetch_entry_t e;
        int           lat;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clock);
            cyc++;
            if (reset === 1'b1) begin
                pipe.delete();
                exp_q.delete();
                outstanding = 0;
                epoch++;
                fetch_on  = 0;
                exp_req   = RESET_PC;
                fetched_m = 0;
                flushed_m = 0;
            end else begin
                if (imem_rsp_valid && pipe.size() > 0) begin
                    outstanding--;
                    head = pipe.pop_front();
                    if (!redir_valid && head.epoch == epoch) begin
                        e.pc    = head.addr;
                        e.instr = mem_fn(head.addr);
                        exp_q.push_back(e);
                    end else begin
                        flushed_m++;
                    end
                end
                if (!redir_valid && dec_valid && dec_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    fetched_m++;
                    pops++;
                end
                if (redir_valid) begin
                    flushed_m += exp_q.size();
                    exp_q.delete();
                    epoch++;
                    exp_req = {redir_pc[31:2], 2'b00};
                end
                if (imem_req_valid && imem_req_ready) begin
                    lat = $urandom_range(lat_max, lat_min);
                    pipe.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + lat - 1});
                    outstanding++;
                    exp_req = exp_req + 32'd4;
                    accepted_cnt++;
                    last_addr = imem_req_addr;
                end
                fetch_on = run;
            end
            #2;
            case (ready_mode)
                0:       imem_req_ready = 1'b1;
                1:       imem_req_ready = 1'($urandom_range(1, 0));
                default: imem_req_ready = 1'b0;
            endcase
            if (reset !== 1'b1 && pipe.size() > 0 && pipe[0].due <= cyc &&
                (!rsp_gaps || $urandom_range(3, 0) != 0)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_fn(pipe[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end
    end

    always @(negedge clock) begin : monitor
        bit exp_rv;
        if (reset === 1'b0) begin
            n_checks++;
            if (dec_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL mon_dec_valid t=%0t: got %b want %b", $time, dec_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0 && dec_valid === 1'b1) begin
                n_checks++;
                if (dec_pc !== exp_q[0].pc || dec_instr !== exp_q[0].instr) begin
                    n_fail++;
                    $display("FAIL mon_dec_head t=%0t: got pc=%h instr=%h want pc=%h instr=%h",
                             $time, dec_pc, dec_instr, exp_q[0].pc, exp_q[0].instr);
                end
            end
            exp_rv = fetch_on && !redir_valid && (outstanding + exp_q.size() < DEPTH);
            n_checks++;
            if (imem_req_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL mon_req_valid t=%0t: got %b want %b", $time, imem_req_valid, exp_rv);
            end
            if (imem_req_valid === 1'b1 && exp_rv) begin
                n_checks++;
                if (imem_req_addr !== exp_req) begin
                    n_fail++;
                    $display("FAIL mon_req_addr t=%0t: got %h want %h", $time, imem_req_addr, exp_req);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        run = 1'b0;
        redir_valid = 1'b0;
        dec_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b0;
        redir_valid = 1'b0;
        redir_pc = '0;
        dec_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got dec=%b req=%b want 0 0", dec_valid, imem_req_valid);
        end
        n_checks++;
        if (imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_pc: got %h want %h", imem_req_addr, RESET_PC);
        end
        n_checks++;
        if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dec: got pc=%h instr=%h want 0 0", dec_pc, dec_instr);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int k;
        int base;
        do_reset();
        ready_mode = 0; lat_min = 3; lat_max = 3; rsp_gaps = 0;
        run = 1'b1;
        dec_ready = 1'b1;
        k = 0;
        while (outstanding < 2 && k < 50) begin @(posedge clock); #1; k++; end
        n_checks++;
        if (outstanding < 2) begin
            n_fail++;
            $display("FAIL midrun_inflight: got %0d want >=2", outstanding);
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        base = accepted_cnt;
        k = 0;
        while (accepted_cnt == base && k < 50) begin @(posedge clock); #1; k++; end
        n_checks++;
        if (accepted_cnt == base || last_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL midrun_first_addr: got %h want %h", last_addr, RESET_PC);
        end
        k = 0;
        do begin @(negedge clock); k++; end while (dec_valid !== 1'b1 && k < 50);
        n_checks++;
        if (dec_valid !== 1'b1 || dec_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL midrun_first_dec: got valid=%b pc=%h want 1 %h", dec_valid, dec_pc, RESET_PC);
        end
        base = pops;
        k = 0;
        while (pops - base < 8 && k < 200) begin @(posedge clock); #1; k++; end
        n_checks++;
        if (pops - base < 8) begin
            n_fail++;
            $display("FAIL midrun_progress: got %0d pops want 8", pops - base);
        end
    endtask

    task automatic test_credit_limit();
        int base;
        bit found;
        do_reset();
        ready_mode = 0; lat_min = 3; lat_max = 3; rsp_gaps = 0;
        base = accepted_cnt;
        run = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (accepted_cnt - base != DEPTH) begin
            n_fail++;
            $display("FAIL credit_issued: got %0d want %0d", accepted_cnt - base, DEPTH);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0 || dec_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_stall: got req=%b dec=%b want 0 1", imem_req_valid, dec_valid);
        end
        @(posedge clock); #1 dec_ready = 1'b1;
        @(posedge clock); #1 dec_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clock);
            if (imem_req_valid === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL credit_resume: got req_valid=0 want 1 after pop");
        end
    endtask

    task automatic test_redirect_stale();
        int k;
        int base;
        do_reset();
        ready_mode = 2; lat_min = 4; lat_max = 4; rsp_gaps = 0;
        run = 1'b1;
        ready_mode = 0;
        base = accepted_cnt;
        k = 0;
        while (accepted_cnt - base < 2 && k < 50) begin @(posedge clock); #1; k++; end
        ready_mode = 2;
        redir_valid = 1'b1;
        redir_pc = 32'h0000_0203;
        n_checks++;
        if (outstanding != 2) begin
            n_fail++;
            $display("FAIL stale_inflight: got %0d want 2", outstanding);
        end
        @(posedge clock);
        #1;
        redir_valid = 1'b0;
        ready_mode = 0;
        dec_ready = 1'b1;
        base = accepted_cnt;
        k = 0;
        while (accepted_cnt == base && k < 50) begin @(posedge clock); #1; k++; end
        n_checks++;
        if (accepted_cnt == base || last_addr !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL stale_redir_addr: got %h want 00000200", last_addr);
        end
        k = 0;
        do begin @(negedge clock); k++; end while (dec_valid !== 1'b1 && k < 50);
        n_checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0000_0200 || dec_instr !== mem_fn(32'h200)) begin
            n_fail++;
            $display("FAIL stale_first_dec: got pc=%h instr=%h want 00000200 %h",
                     dec_pc, dec_instr, mem_fn(32'h200));
        end
    endtask

    task automatic test_redirect_collision();
        int k;
        bit found;
        do_reset();
        ready_mode = 0; lat_min = 3; lat_max = 3; rsp_gaps = 0;
        run = 1'b1;
        dec_ready = 1'b1;
        found = 0;
        k = 0;
        while (!found && k < 60) begin
            @(posedge clock);
            #3;
            if (imem_rsp_valid && dec_valid && outstanding >= 2) found = 1;
            k++;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL collide_setup: got no rsp+pop cycle want one");
        end
        redir_valid = 1'b1;
        redir_pc = 32'h0000_0400;
        @(posedge clock);
        #1 redir_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_flush: got dec_valid=%b want 0", dec_valid);
        end
        k = 0;
        do begin @(negedge clock); k++; end while (dec_valid !== 1'b1 && k < 50);
        n_checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL collide_first_dec: got valid=%b pc=%h want 1 00000400", dec_valid, dec_pc);
        end
    endtask

    task automatic test_pc_wrap();
        int k;
        int base;
        do_reset();
        ready_mode = 0; lat_min = 2; lat_max = 2; rsp_gaps = 0;
        dec_ready = 1'b1;
        redir_valid = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        run = 1'b1;
        @(posedge clock);
        #1 redir_valid = 1'b0;
        base = accepted_cnt;
        k = 0;
        while (accepted_cnt - base < 1 && k < 50) begin @(posedge clock); #1; k++; end
        n_checks++;
        if (last_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got %h want fffffffc", last_addr);
        end
        k = 0;
        while (accepted_cnt - base < 2 && k < 50) begin @(posedge clock); #1; k++; end
        n_checks++;
        if (accepted_cnt - base < 2 || last_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_second: got %h want 00000000", last_addr);
        end
    endtask

    task automatic test_random();
        int k;
        int base;
        do_reset();
        ready_mode = 1; lat_min = 1; lat_max = 5; rsp_gaps = 1;
        base = pops;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock);
            #1;
            run = ($urandom_range(9, 0) != 0);
            dec_ready = 1'($urandom_range(1, 0));
            redir_valid = ($urandom_range(31, 0) == 0);
            redir_pc = $urandom;
        end
        @(posedge clock);
        #1;
        redir_valid = 1'b0;
        run = 1'b0;
        dec_ready = 1'b1;
        rsp_gaps = 0;
        k = 0;
        while ((outstanding != 0 || exp_q.size() != 0) && k < 100) begin @(posedge clock); #1; k++; end
        n_checks++;
        if (outstanding != 0 || exp_q.size() != 0 || pops - base < 100) begin
            n_fail++;
            $display("FAIL random_drain: got outstanding=%0d queued=%0d pops=%0d want 0 0 >=100",
                     outstanding, exp_q.size(), pops - base);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_idle: got dec=%b req=%b want 0 0", dec_valid, imem_req_valid);
        end
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic test_perf();
        int k;
        int base;
        do_reset();
        @(negedge clock);
        n_checks++;
        if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %0d %0d want 0 0", perf_fetched, perf_flushed);
        end
        ready_mode = 0; lat_min = 2; lat_max = 2; rsp_gaps = 0;
        @(posedge clock);
        #1;
        run = 1'b1;
        dec_ready = 1'b1;
        base = pops;
        k = 0;
        while (pops - base < 10 && k < 200) begin @(posedge clock); #1; k++; end
        dec_ready = 1'b0;
        run = 1'b0;
        k = 0;
        while (outstanding != 0 && k < 50) begin @(posedge clock); #1; k++; end
        redir_valid = 1'b1;
        redir_pc = 32'h0000_0800;
        @(posedge clock);
        #1 redir_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (perf_fetched !== 32'd10) begin
            n_fail++;
            $display("FAIL perf_fetched: got %0d want 10", perf_fetched);
        end
        n_checks++;
        if (perf_flushed !== 32'(flushed_m) || flushed_m == 0) begin
            n_fail++;
            $display("FAIL perf_flushed: got %0d want %0d (nonzero)", perf_flushed, flushed_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_run();
        test_credit_limit();
        test_redirect_stale();
        test_redirect_collision();
        test_pc_wrap();
        test_random();
`ifdef IFU_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
